// File: rtl/wm8731_cfg_seq.sv
// WM8731 control-port sequencer: runs a fixed boot table, then serves single host
// register writes, each as one 24-bit I2C word with NACK/timeout retry and bus-free gap.
module wm8731_cfg_seq #(
  parameter logic [7:0] DEV_ADDR    = 8'h34,
  parameter int         MAX_RETRY   = 3,
  parameter int         TIMEOUT_CYC = 4096,
  parameter int         GAP_CYC     = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        host_req,
  input  logic [15:0] host_data,
  output logic        host_ack,
  output logic        host_err,
  output logic        i2c_go,
  output logic [23:0] i2c_data,
  input  logic        i2c_done,
  input  logic        i2c_ack_ok,
  output logic        busy,
  output logic        init_done,
  output logic        error,
  output logic [7:0]  fail_cnt,
  output logic [2:0]  dbg_state
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_ISSUE = 3'd2,
    ST_WAIT  = 3'd3,
    ST_EVAL  = 3'd4,
    ST_GAP   = 3'd5
  } state_t;

  localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam int GW = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
  localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT_CYC - 1);
  localparam logic [GW-1:0] GAP_LAST  = GW'(GAP_CYC - 1);
  localparam logic [RW-1:0] RETRY_MAX = RW'(MAX_RETRY);

  state_t          r_state, w_state_nxt;
  logic            r_src_host;
  logic [3:0]      r_index;
  logic [RW-1:0]   r_retry;
  logic            r_retry_pend;
  logic [TW-1:0]   r_tmo;
  logic [GW-1:0]   r_gap;
  logic            r_ok;
  logic            r_init_pending;
  logic            r_init_done;
  logic            r_error;
  logic [7:0]      r_fail_cnt;
  logic [23:0]     r_i2c_data;

  logic            w_tmo;
  logic            w_gap_end;
  logic            w_can_retry;
  logic            w_table_more;

  function automatic logic [15:0] boot_word(input logic [3:0] idx);
    case (idx)
      4'd0:    boot_word = {7'd15, 9'h000};
      4'd1:    boot_word = {7'd0,  9'h017};
      4'd2:    boot_word = {7'd1,  9'h017};
      4'd3:    boot_word = {7'd2,  9'h079};
      4'd4:    boot_word = {7'd3,  9'h079};
      4'd5:    boot_word = {7'd4,  9'h012};
      4'd6:    boot_word = {7'd5,  9'h000};
      4'd7:    boot_word = {7'd6,  9'h000};
      4'd8:    boot_word = {7'd7,  9'h042};
      4'd9:    boot_word = {7'd9,  9'h001};
      default: boot_word = 16'h0000;
    endcase
  endfunction

  assign w_tmo        = (r_tmo == TMO_LAST);
  assign w_gap_end    = (r_gap == GAP_LAST);
  assign w_can_retry  = (r_retry < RETRY_MAX);
  assign w_table_more = !r_src_host && r_init_pending && (r_index != 4'd10);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (r_init_pending || (host_req && r_init_done)) w_state_nxt = ST_LOAD;
      ST_LOAD:  w_state_nxt = ST_ISSUE;
      ST_ISSUE: w_state_nxt = ST_WAIT;
      ST_WAIT:  if (i2c_done || w_tmo) w_state_nxt = ST_EVAL;
      ST_EVAL:  w_state_nxt = ST_GAP;
      ST_GAP: begin
        if (w_gap_end) begin
          if (r_retry_pend)      w_state_nxt = ST_ISSUE;
          else if (w_table_more) w_state_nxt = ST_LOAD;
          else                   w_state_nxt = ST_IDLE;
        end
      end
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_src_host     <= 1'b0;
      r_index        <= 4'd0;
      r_retry        <= '0;
      r_retry_pend   <= 1'b0;
      r_tmo          <= '0;
      r_gap          <= '0;
      r_ok           <= 1'b0;
      r_init_pending <= 1'b0;
      r_init_done    <= 1'b0;
      r_error        <= 1'b0;
      r_fail_cnt     <= 8'd0;
      r_i2c_data     <= 24'd0;
    end else begin
      // A start while the table is already pending is dropped; a host word in flight finishes first.
      if (start && !r_init_pending) begin
        r_init_pending <= 1'b1;
        r_init_done    <= 1'b0;
        r_error        <= 1'b0;
        r_index        <= 4'd0;
      end
      case (r_state)
        ST_IDLE: begin
          if (r_init_pending)               r_src_host <= 1'b0;
          else if (host_req && r_init_done) r_src_host <= 1'b1;
        end
        ST_LOAD: begin
          r_i2c_data   <= {DEV_ADDR, r_src_host ? host_data : boot_word(r_index)};
          r_retry      <= '0;
          r_retry_pend <= 1'b0;
        end
        ST_ISSUE: r_tmo <= '0;
        ST_WAIT: begin
          if (i2c_done)   r_ok  <= i2c_ack_ok;
          else if (w_tmo) r_ok  <= 1'b0;
          else            r_tmo <= r_tmo + 1'b1;
        end
        ST_EVAL: begin
          r_gap <= '0;
          if (r_ok) begin
            r_retry_pend <= 1'b0;
            if (!r_src_host) r_index <= r_index + 1'b1;
          end else begin
            if (r_fail_cnt != 8'hFF) r_fail_cnt <= r_fail_cnt + 1'b1;
            if (w_can_retry) begin
              r_retry      <= r_retry + 1'b1;
              r_retry_pend <= 1'b1;
            end else begin
              r_retry_pend <= 1'b0;
              if (!r_src_host) begin
                r_error        <= 1'b1;
                r_init_pending <= 1'b0;
                r_index        <= 4'd0;
              end
            end
          end
        end
        ST_GAP: begin
          r_gap <= r_gap + 1'b1;
          if (w_gap_end) begin
            r_retry_pend <= 1'b0;
            if (!r_retry_pend && !r_src_host && r_init_pending && (r_index == 4'd10)) begin
              r_init_done    <= 1'b1;
              r_init_pending <= 1'b0;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Host handshake: host raises host_req with host_data stable and holds both until
  // host_ack (one cycle, in EVAL); host_err qualifies that pulse. A request is taken
  // only from IDLE once init_done is set; a level still high on return to IDLE is a new word.
  assign host_ack  = (r_state == ST_EVAL) && r_src_host && (r_ok || !w_can_retry);
  assign host_err  = (r_state == ST_EVAL) && r_src_host && !r_ok && !w_can_retry;
  assign i2c_go    = (r_state == ST_ISSUE);
  assign i2c_data  = r_i2c_data;
  assign busy      = (r_state != ST_IDLE);
  assign init_done = r_init_done;
  assign error     = r_error;
  assign fail_cnt  = r_fail_cnt;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_wm8731_cfg_seq.sv
// Bench for wm8731_cfg_seq: behavioural I2C engine model, boot-table and host-write
// vector table, plus hand sequences for retry, failure, timeout and reset corners.
module tb_wm8731_cfg_seq;
  localparam int GAP_CYC     = 64;
  localparam int TIMEOUT_CYC = 4096;
  localparam int MAX_RETRY   = 3;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        host_req = 1'b0;
  logic [15:0] host_data = 16'h0000;
  logic        host_ack, host_err, i2c_go;
  logic [23:0] i2c_data;
  logic        i2c_done, i2c_ack_ok;
  logic        busy, init_done, error;
  logic [7:0]  fail_cnt;
  logic [2:0]  dbg_state;

  wm8731_cfg_seq #(
    .DEV_ADDR(8'h34), .MAX_RETRY(MAX_RETRY), .TIMEOUT_CYC(TIMEOUT_CYC), .GAP_CYC(GAP_CYC)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .host_req(host_req), .host_data(host_data),
    .host_ack(host_ack), .host_err(host_err), .i2c_go(i2c_go), .i2c_data(i2c_data),
    .i2c_done(i2c_done), .i2c_ack_ok(i2c_ack_ok), .busy(busy), .init_done(init_done),
    .error(error), .fail_cnt(fail_cnt), .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // engine model (owns i2c_done/i2c_ack_ok, the go log and the response index)
  int          eng_delay = 100;
  bit          eng_silent = 1'b0;
  bit          plan_q[$];          // per response after plan_off: 0 = NACK; beyond plan = ACK
  int          plan_off = 0;
  int          resp_idx = 0;
  int          spur_req = 0;
  int          spur_done = 0;
  int          eng_unstable = 0;
  int          done_cyc = 0;
  logic [23:0] go_data_q[$];
  int          go_cyc_q[$];

  initial begin : engine
    logic [23:0] held;
    bit          aborted;
    int          k;
    i2c_done = 1'b0;
    i2c_ack_ok = 1'b0;
    forever begin
      @(negedge clk);
      if (spur_req != spur_done) begin
        i2c_done = 1'b1; i2c_ack_ok = 1'b0;
        @(negedge clk);
        i2c_done = 1'b0;
        spur_done++;
      end else if (i2c_go && !reset) begin
        held = i2c_data;
        go_data_q.push_back(i2c_data);
        go_cyc_q.push_back(cyc);
        if (!eng_silent) begin
          aborted = 1'b0;
          for (int j = 1; j < eng_delay; j++) begin
            @(negedge clk);
            if (reset) begin aborted = 1'b1; break; end
          end
          if (!aborted) begin
            if (i2c_data !== held) eng_unstable++;
            k = resp_idx - plan_off;
            i2c_ack_ok = (k >= 0 && k < plan_q.size()) ? plan_q[k] : 1'b1;
            resp_idx++;
            i2c_done = 1'b1;
            done_cyc = cyc;
            @(negedge clk);
            i2c_done = 1'b0; i2c_ack_ok = 1'b0;
          end
        end
      end
    end
  end

  // scoreboard
  int n_checks = 0;
  int n_fail = 0;
  logic [23:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // driver tasks
  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; start = 1'b0; host_req = 1'b0;
    @(negedge clk);
    check("rst_flags", {host_ack, host_err, i2c_go, busy, init_done, error}, 6'b0);
    check("rst_fail_cnt", fail_cnt, 8'd0);
    check("rst_i2c_data", i2c_data, 24'd0);
    check("rst_state", dbg_state, 3'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic pulse_start();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic set_plan(input int nack_before, input int nacks);
    plan_off = resp_idx;
    plan_q = {};
    for (int i = 0; i < nack_before; i++) plan_q.push_back(1'b1);
    for (int i = 0; i < nacks; i++) plan_q.push_back(1'b0);
  endtask

  task automatic wait_idle(input string name, input int budget);
    int n = 0;
    repeat (3) @(negedge clk);
    while (busy && n < budget) begin @(negedge clk); n++; end
    check(name, busy, 1'b0);
  endtask

  task automatic wait_goes(input int n, input int budget);
    int k = 0;
    while (go_data_q.size() < n && k < budget) begin @(negedge clk); k++; end
    check("wait_goes", go_data_q.size() >= n, 1'b1);
  endtask

  task automatic host_write(input logic [15:0] d, input int budget,
                            output logic err, output int go_lat, output int ack_lat);
    int n = 0;
    int req_cyc;
    int b;
    @(negedge clk);
    host_req = 1'b1; host_data = d; req_cyc = cyc; b = go_cyc_q.size();
    while (!host_ack && n < budget) begin @(negedge clk); n++; end
    check("host_ack_seen", host_ack, 1'b1);
    err = host_err;
    ack_lat = cyc - done_cyc;
    host_req = 1'b0;
    go_lat = (go_cyc_q.size() > b) ? go_cyc_q[b] - req_cyc : -1;
  endtask

  typedef struct {
    logic [15:0] hdata;
    int          nacks;
    logic [23:0] exp_data;
    logic        exp_err;
    logic [7:0]  exp_fail;
    int          exp_goes;
  } hvec_t;

  hvec_t hv[5];

  initial begin : main
    int   b;
    logic err;
    int   glat, alat;

    hv[0] = '{16'h0E42, 0, 24'h340E42, 1'b0, 8'd0, 1};
    hv[1] = '{16'h0A06, 1, 24'h340A06, 1'b0, 8'd1, 2};
    hv[2] = '{16'hFFFF, 0, 24'h34FFFF, 1'b0, 8'd1, 1};
    hv[3] = '{16'h1201, 4, 24'h341201, 1'b1, 8'd5, 4};
    hv[4] = '{16'h0000, 3, 24'h340000, 1'b0, 8'd8, 4};
    exp_q = '{24'h341E00, 24'h340017, 24'h340217, 24'h340479, 24'h340679,
              24'h340812, 24'h340A00, 24'h340C00, 24'h340E42, 24'h341201};

    // 1: clean boot, with a second start mid-table that must be ignored
    do_reset();
    set_plan(0, 0);
    b = go_data_q.size();
    pulse_start();
    wait_goes(b + 3, 2000);
    pulse_start();
    wait_idle("boot_idle", 6000);
    check("boot_goes", go_data_q.size() - b, 10);
    for (int i = 0; i < 10; i++) begin
      check("boot_word", go_data_q[b + i], exp_q[i]);
      if (i > 0) check("boot_sep", (go_cyc_q[b + i] - go_cyc_q[b + i - 1]) >= GAP_CYC + 3, 1'b1);
    end
    check("boot_done", {init_done, error}, 2'b10);
    check("boot_fail_cnt", fail_cnt, 8'd0);

    // spurious i2c_done while idle is ignored
    spur_req++;
    repeat (5) @(negedge clk);
    check("spur_fail_cnt", fail_cnt, 8'd0);
    check("spur_idle", {busy, i2c_go}, 2'b00);
    check("spur_goes", go_data_q.size() - b, 10);

    // 4: host request before init_done is held off, served after the table
    do_reset();
    set_plan(0, 0);
    b = go_data_q.size();
    @(negedge clk); host_req = 1'b1; host_data = 16'h0E42;
    repeat (50) @(negedge clk);
    check("hold_off_goes", go_data_q.size() - b, 0);
    check("hold_off_busy", {busy, host_ack}, 2'b00);
    pulse_start();
    begin
      int n = 0;
      while (!host_ack && n < 6000) begin @(negedge clk); n++; end
    end
    check("late_host_ack", {host_ack, host_err}, 2'b10);
    check("late_host_ack_lat", cyc - done_cyc, 1);
    host_req = 1'b0;
    check("late_goes", go_data_q.size() - b, 11);
    check("late_first", go_data_q[b], 24'h341E00);
    check("late_host_word", go_data_q[b + 10], 24'h340E42);
    wait_idle("late_idle", 200);

    // host write vector table
    for (int v = 0; v < 5; v++) begin
      set_plan(0, hv[v].nacks);
      b = go_data_q.size();
      host_write(hv[v].hdata, 3000, err, glat, alat);
      check("hv_err", err, hv[v].exp_err);
      check("hv_go_lat", glat, 2);
      check("hv_ack_lat", alat, 1);
      wait_idle("hv_idle", 200);
      check("hv_fail_cnt", fail_cnt, hv[v].exp_fail);
      check("hv_goes", go_data_q.size() - b, hv[v].exp_goes);
      for (int i = b; i < go_data_q.size(); i++) check("hv_data", go_data_q[i], hv[v].exp_data);
    end

    // 2: table word 3 NACKed twice then ACKed
    do_reset();
    set_plan(3, 2);
    b = go_data_q.size();
    pulse_start();
    wait_idle("nack2_idle", 6000);
    check("nack2_goes", go_data_q.size() - b, 12);
    for (int i = 3; i < 6; i++) check("nack2_word", go_data_q[b + i], 24'h340479);
    check("nack2_sep1", (go_cyc_q[b + 4] - go_cyc_q[b + 3]) >= GAP_CYC + 3, 1'b1);
    check("nack2_sep2", (go_cyc_q[b + 5] - go_cyc_q[b + 4]) >= GAP_CYC + 3, 1'b1);
    check("nack2_last", go_data_q[b + 11], 24'h341201);
    check("nack2_fail_cnt", fail_cnt, 8'd2);
    check("nack2_done", {init_done, error}, 2'b10);

    // 3: table word 5 NACKed beyond the retry budget, then rerun
    do_reset();
    set_plan(5, 4);
    b = go_data_q.size();
    pulse_start();
    wait_idle("fail_idle", 6000);
    repeat (200) @(negedge clk);
    check("fail_goes", go_data_q.size() - b, 9);
    for (int i = 5; i < 9; i++) check("fail_word", go_data_q[b + i], 24'h340812);
    check("fail_flags", {init_done, error}, 2'b01);
    check("fail_fail_cnt", fail_cnt, 8'd4);
    set_plan(0, 0);
    b = go_data_q.size();
    pulse_start();
    @(negedge clk);
    check("rerun_err_clr", error, 1'b0);
    wait_idle("rerun_idle", 6000);
    check("rerun_goes", go_data_q.size() - b, 10);
    check("rerun_first", go_data_q[b], 24'h341E00);
    check("rerun_flags", {init_done, error}, 2'b10);
    check("rerun_fail_cnt", fail_cnt, 8'd4);

    // 5: engine silent on a host word -> timeouts, retries, host_err
    do_reset();
    set_plan(0, 0);
    pulse_start();
    wait_idle("tmo_boot", 6000);
    eng_silent = 1'b1;
    b = go_data_q.size();
    host_write(16'h0E42, 20000, err, glat, alat);
    check("tmo_err", err, 1'b1);
    wait_idle("tmo_idle", 200);
    check("tmo_goes", go_data_q.size() - b, MAX_RETRY + 1);
    check("tmo_spacing", go_cyc_q[b + 1] - go_cyc_q[b], TIMEOUT_CYC + GAP_CYC + 2);
    check("tmo_fail_cnt", fail_cnt, 8'd4);
    check("tmo_init_kept", {init_done, error}, 2'b10);
    eng_silent = 1'b0;

    // 6: reset during WAIT, then start and host_req together
    do_reset();
    set_plan(0, 0);
    pulse_start();
    wait_goes(go_data_q.size() + 1, 200);
    repeat (20) @(negedge clk);
    check("mid_in_wait", dbg_state, 3'd3);
    @(negedge clk); reset = 1'b1;
    @(negedge clk);
    check("mid_rst_flags", {host_ack, host_err, i2c_go, busy, init_done, error}, 6'b0);
    check("mid_rst_data", i2c_data, 24'd0);
    @(negedge clk); reset = 1'b0;
    b = go_data_q.size();
    @(negedge clk); start = 1'b1; host_req = 1'b1; host_data = 16'h0C05;
    @(negedge clk); start = 1'b0;
    begin
      int n = 0;
      while (!host_ack && n < 6000) begin @(negedge clk); n++; end
    end
    check("mid_host_ack", {host_ack, host_err}, 2'b10);
    host_req = 1'b0;
    check("mid_goes", go_data_q.size() - b, 11);
    check("mid_first", go_data_q[b], 24'h341E00);
    check("mid_tenth", go_data_q[b + 9], 24'h341201);
    check("mid_host_word", go_data_q[b + 10], 24'h340C05);
    check("mid_fail_cnt", fail_cnt, 8'd0);
    wait_idle("mid_idle", 200);

    check("data_stable", eng_unstable, 0);

    // final report
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
